// File: rtl/rans_enc_lanes.sv
// Multi-lane interleaved rANS encoder: round-robin lane states, host-loaded freq/cum table, streamed renorm words.
// Define RANS_ENC_RADIX4_DIV_EN for a 2-bit-per-cycle divider; output words are identical either way.
module rans_enc_lanes #(
   parameter int RESOLUTION   = 10,
   parameter int SYMBOL_WIDTH = 8,
   parameter int STATE_WIDTH  = 32,
   parameter int WORD_WIDTH   = 16,
   parameter int LANES        = 2,
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    freq_wr_i,
   input  logic [RESOLUTION-1:0]   freq_i,
   input  logic [RESOLUTION-1:0]   cum_freq_i,
   input  logic [SYMBOL_WIDTH-1:0] symb_i,
   input  logic                    sym_valid_i,
   output logic                    sym_ready_o,
   input  logic                    restart_i,
   input  logic                    flush_i,
   output logic                    enc_valid_o,
   input  logic                    enc_ready_i,
   output logic [WORD_WIDTH-1:0]   enc_o,
   output logic [LW-1:0]           enc_lane_o,
   output logic                    enc_last_o,
   output logic                    busy_o
);

   localparam int NW  = STATE_WIDTH / WORD_WIDTH;
   localparam int NWW = (NW > 1) ? $clog2(NW) : 1;
   localparam int RQW = RESOLUTION + STATE_WIDTH;
   localparam int CW  = $clog2(STATE_WIDTH + 2);
`ifdef RANS_ENC_RADIX4_DIV_EN
   localparam int ITER = STATE_WIDTH / 2;
`else
   localparam int ITER = STATE_WIDTH;
`endif
   localparam logic [CW-1:0]          CNT_LAST  = CW'(ITER + 1);
   localparam logic [LW-1:0]          LAST_LANE = LW'(LANES - 1);
   localparam logic [NWW-1:0]         LAST_WORD = NWW'(NW - 1);
   localparam logic [STATE_WIDTH-1:0] L_INIT    = STATE_WIDTH'(1) << (STATE_WIDTH - WORD_WIDTH);

   typedef enum logic [2:0] {IDLE, EMIT, DIV, UPDATE, FLUSH} state_t;

   state_t                    state_q;
   logic [STATE_WIDTH-1:0]    lane_q [LANES];
   logic [LW-1:0]             ptr_q;
   logic [LW-1:0]             sel_q;
   logic [STATE_WIDTH-1:0]    x_q;
   logic [RESOLUTION-1:0]     f_q;
   logic [RESOLUTION-1:0]     c_q;
   logic [RQW-1:0]            rq_q;
   logic [CW-1:0]             cnt_q;
   logic [LW-1:0]             fl_lane_q;
   logic [NWW-1:0]            fl_word_q;
   logic [2*RESOLUTION-1:0]   tbl [2**SYMBOL_WIDTH];

   logic [2*RESOLUTION-1:0]   tbl_rd;
   logic [RESOLUTION-1:0]     rd_f;
   logic [RESOLUTION-1:0]     rd_c;
   logic [STATE_WIDTH-1:0]    cur_x;
   logic                      need_emit;
   logic [RQW-1:0]            rq_step1;
   logic [RQW-1:0]            rq_next;
   logic [LW-1:0]             nxt_lane;
   logic [NWW-1:0]            nxt_word;
   logic [WORD_WIDTH-1:0]     nxt_data;
   logic                      nxt_last;

   // One restoring step on {remainder, quotient}: shift in the next dividend bit and subtract if it fits.
   function automatic logic [RQW-1:0] div_step(input logic [RQW-1:0] rq, input logic [RESOLUTION-1:0] d);
      logic [RESOLUTION:0] sh;
      logic [RESOLUTION:0] diff;
      sh   = {rq[RQW-1:STATE_WIDTH], rq[STATE_WIDTH-1]};
      diff = sh - {1'b0, d};
      if (sh >= {1'b0, d}) return {diff[RESOLUTION-1:0], rq[STATE_WIDTH-2:0], 1'b1};
      else                 return {sh[RESOLUTION-1:0], rq[STATE_WIDTH-2:0], 1'b0};
   endfunction

   assign sym_ready_o = (state_q == IDLE) && !restart_i && !freq_wr_i && !flush_i;
   assign busy_o      = (state_q != IDLE);

   always_ff @(posedge clk_i) begin
      if ((state_q == IDLE) && !restart_i && freq_wr_i)
         tbl[symb_i] <= {freq_i, cum_freq_i};
   end

   always_comb begin
      tbl_rd    = tbl[symb_i];
      rd_f      = tbl_rd[2*RESOLUTION-1:RESOLUTION];
      rd_c      = tbl_rd[RESOLUTION-1:0];
      cur_x     = lane_q[ptr_q];
      need_emit = cur_x >= (STATE_WIDTH'(rd_f) << (STATE_WIDTH - RESOLUTION));
      rq_step1  = div_step(rq_q, f_q);
`ifdef RANS_ENC_RADIX4_DIV_EN
      rq_next   = div_step(rq_step1, f_q);
`else
      rq_next   = rq_step1;
`endif
   end

   // Flush walks lanes from the top down, low word first within each lane.
   always_comb begin
      nxt_lane = fl_lane_q;
      nxt_word = fl_word_q + 1'b1;
      if (fl_word_q == LAST_WORD) begin
         nxt_lane = fl_lane_q - 1'b1;
         nxt_word = '0;
      end
      nxt_data = WORD_WIDTH'(lane_q[nxt_lane] >> (32'(nxt_word) * WORD_WIDTH));
      nxt_last = (nxt_lane == '0) && (nxt_word == LAST_WORD);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         for (int i = 0; i < LANES; i++) lane_q[i] <= L_INIT;
         ptr_q       <= '0;
         sel_q       <= '0;
         x_q         <= '0;
         f_q         <= '0;
         c_q         <= '0;
         rq_q        <= '0;
         cnt_q       <= '0;
         fl_lane_q   <= '0;
         fl_word_q   <= '0;
         enc_valid_o <= 1'b0;
         enc_o       <= '0;
         enc_lane_o  <= '0;
         enc_last_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (restart_i) begin
                  for (int i = 0; i < LANES; i++) lane_q[i] <= L_INIT;
                  ptr_q <= '0;
               end else if (freq_wr_i) begin
                  state_q <= IDLE;
               end else if (flush_i) begin
                  state_q     <= FLUSH;
                  fl_lane_q   <= LAST_LANE;
                  fl_word_q   <= '0;
                  enc_valid_o <= 1'b1;
                  enc_o       <= lane_q[LAST_LANE][WORD_WIDTH-1:0];
                  enc_lane_o  <= LAST_LANE;
                  enc_last_o  <= (LAST_LANE == '0) && (LAST_WORD == '0);
               end else if (sym_valid_i && (rd_f != '0)) begin
                  // Zero-frequency symbols fall through here and are silently dropped.
                  x_q   <= cur_x;
                  f_q   <= rd_f;
                  c_q   <= rd_c;
                  sel_q <= ptr_q;
                  cnt_q <= '0;
                  ptr_q <= (ptr_q == LAST_LANE) ? '0 : ptr_q + 1'b1;
                  if (need_emit) begin
                     state_q     <= EMIT;
                     enc_valid_o <= 1'b1;
                     enc_o       <= cur_x[WORD_WIDTH-1:0];
                     enc_lane_o  <= ptr_q;
                     enc_last_o  <= 1'b0;
                  end else begin
                     state_q <= DIV;
                  end
               end
            end
            EMIT: begin
               if (enc_ready_i) begin
                  enc_valid_o <= 1'b0;
                  x_q         <= x_q >> WORD_WIDTH;
                  state_q     <= DIV;
               end
            end
            DIV: begin
               // Operand load, ITER divider cycles, then fold quotient and remainder into x.
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '0) begin
                  rq_q <= {{RESOLUTION{1'b0}}, x_q};
               end else if (cnt_q == CNT_LAST) begin
                  x_q     <= {rq_q[STATE_WIDTH-RESOLUTION-1:0], rq_q[RQW-1:STATE_WIDTH]};
                  state_q <= UPDATE;
               end else begin
                  rq_q <= rq_next;
               end
            end
            UPDATE: begin
               lane_q[sel_q] <= x_q + {{(STATE_WIDTH-RESOLUTION){1'b0}}, c_q};
               state_q       <= IDLE;
            end
            FLUSH: begin
               if (enc_ready_i) begin
                  if (enc_last_o) begin
                     enc_valid_o <= 1'b0;
                     enc_last_o  <= 1'b0;
                     for (int i = 0; i < LANES; i++) lane_q[i] <= L_INIT;
                     ptr_q       <= '0;
                     state_q     <= IDLE;
                  end else begin
                     fl_lane_q  <= nxt_lane;
                     fl_word_q  <= nxt_word;
                     enc_o      <= nxt_data;
                     enc_lane_o <= nxt_lane;
                     enc_last_o <= nxt_last;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rans_enc_lanes.sv
// Directed self-checking bench for rans_enc_lanes at default parameters (LANES=2).
// Latency expectations follow RANS_ENC_RADIX4_DIV_EN when it is defined.
module tb_rans_enc_lanes;

`ifdef RANS_ENC_RADIX4_DIV_EN
   localparam int BASE_LAT = 19;
`else
   localparam int BASE_LAT = 35;
`endif

   logic        clk_i       = 1'b0;
   logic        rst_ni      = 1'b0;
   logic        freq_wr_i   = 1'b0;
   logic [9:0]  freq_i      = '0;
   logic [9:0]  cum_freq_i  = '0;
   logic [7:0]  symb_i      = '0;
   logic        sym_valid_i = 1'b0;
   logic        sym_ready_o;
   logic        restart_i   = 1'b0;
   logic        flush_i     = 1'b0;
   logic        enc_valid_o;
   logic        enc_ready_i = 1'b1;
   logic [15:0] enc_o;
   logic [0:0]  enc_lane_o;
   logic        enc_last_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   logic [17:0] wq[$];

   rans_enc_lanes dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .freq_wr_i(freq_wr_i), .freq_i(freq_i),
      .cum_freq_i(cum_freq_i), .symb_i(symb_i), .sym_valid_i(sym_valid_i),
      .sym_ready_o(sym_ready_o), .restart_i(restart_i), .flush_i(flush_i),
      .enc_valid_o(enc_valid_o), .enc_ready_i(enc_ready_i), .enc_o(enc_o),
      .enc_lane_o(enc_lane_o), .enc_last_o(enc_last_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every word that will transfer on the coming rising edge as {last, lane, word}.
   always @(negedge clk_i) begin
      if (rst_ni && enc_valid_o && enc_ready_i) wq.push_back({enc_last_o, enc_lane_o, enc_o});
   end

   function automatic logic [17:0] rec(input logic last, input logic lane, input logic [15:0] w);
      return {last, lane, w};
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 300) begin
         tick();
         n++;
      end
      if (busy_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL wait_idle: busy_o still %b after %0d cycles, want 0", busy_o, n);
      end
   endtask

   task automatic load_table(input logic [7:0] s, input logic [9:0] f, input logic [9:0] c);
      freq_wr_i  = 1'b1;
      symb_i     = s;
      freq_i     = f;
      cum_freq_i = c;
      tick();
      freq_wr_i  = 1'b0;
   endtask

   task automatic encode(input logic [7:0] s, output int lat);
      symb_i      = s;
      sym_valid_i = 1'b1;
      tick();
      sym_valid_i = 1'b0;
      lat = 0;
      while (!sym_ready_o && lat < 300) begin
         tick();
         lat++;
      end
   endtask

   task automatic do_flush();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      wait_idle();
   endtask

   task automatic do_restart();
      restart_i = 1'b1;
      tick();
      restart_i = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({enc_valid_o, enc_o, enc_lane_o, enc_last_o, busy_o} !== 20'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h, want 00000",
                  {enc_valid_o, enc_o, enc_lane_o, enc_last_o, busy_o});
      end
      rst_ni = 1'b1;
      tick();
      checks++;
      if (sym_ready_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_ready: got %b, want 1", sym_ready_o);
      end
   endtask

   task automatic test_encode_flush();
      int lat;
      logic [17:0] exp[4];
      wq.delete();
      load_table(8'h41, 10'd512, 10'd0);
      encode(8'h41, lat);
      checks++;
      if (lat != BASE_LAT) begin
         errors++;
         $display("[TB] FAIL enc1_latency: got %0d, want %0d", lat, BASE_LAT);
      end
      checks++;
      if (wq.size() != 0) begin
         errors++;
         $display("[TB] FAIL enc1_no_words: got %0d words, want 0", wq.size());
      end
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0000), rec(1, 0, 16'h0002)};
      checks++;
      if (wq.size() != 4) begin
         errors++;
         $display("[TB] FAIL enc1_flush_count: got %0d, want 4", wq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL enc1_flush_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   task automatic test_renorm();
      int lat1, lat2, lat3;
      logic [17:0] exp[4];
      wq.delete();
      load_table(8'h07, 10'd1, 10'd5);
      encode(8'h07, lat1);
      encode(8'h07, lat2);
      checks++;
      if (lat1 != BASE_LAT || lat2 != BASE_LAT || wq.size() != 0) begin
         errors++;
         $display("[TB] FAIL renorm_first_two: got lat %0d/%0d words %0d, want lat %0d words 0",
                  lat1, lat2, wq.size(), BASE_LAT);
      end
      encode(8'h07, lat3);
      checks++;
      if (lat3 != BASE_LAT + 1) begin
         errors++;
         $display("[TB] FAIL renorm_latency: got %0d, want %0d", lat3, BASE_LAT + 1);
      end
      checks++;
      if (wq.size() != 1 || wq[0] !== rec(0, 0, 16'h0005)) begin
         errors++;
         $display("[TB] FAIL renorm_word: got %0d words first %h, want 1 word %h",
                  wq.size(), (wq.size() > 0) ? wq[0] : 18'bx, rec(0, 0, 16'h0005));
      end
      wq.delete();
      do_flush();
      exp = '{rec(0, 1, 16'h0005), rec(0, 1, 16'h0400), rec(0, 0, 16'h0005), rec(1, 0, 16'h0010)};
      checks++;
      if (wq.size() != 4) begin
         errors++;
         $display("[TB] FAIL renorm_flush_count: got %0d, want 4", wq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL renorm_flush_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   task automatic test_stall();
      int lat;
      do_restart();
      wq.delete();
      encode(8'h07, lat);
      encode(8'h07, lat);
      enc_ready_i = 1'b0;
      symb_i      = 8'h07;
      sym_valid_i = 1'b1;
      tick();
      sym_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({enc_valid_o, enc_o, enc_lane_o, sym_ready_o} !== {1'b1, 16'h0005, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d: got valid %b word %h lane %b ready %b, want 1 0005 0 0",
                     i, enc_valid_o, enc_o, enc_lane_o, sym_ready_o);
         end
         tick();
      end
      enc_ready_i = 1'b1;
      lat = 5;
      while (!sym_ready_o && lat < 300) begin
         tick();
         lat++;
      end
      checks++;
      if (lat != BASE_LAT + 6) begin
         errors++;
         $display("[TB] FAIL stall_latency: got %0d, want %0d", lat, BASE_LAT + 6);
      end
      checks++;
      if (wq.size() != 1 || wq[0] !== rec(0, 0, 16'h0005)) begin
         errors++;
         $display("[TB] FAIL stall_word: got %0d words first %h, want 1 word %h",
                  wq.size(), (wq.size() > 0) ? wq[0] : 18'bx, rec(0, 0, 16'h0005));
      end
   endtask

   task automatic test_zero_freq();
      int lat;
      logic [17:0] exp[4];
      do_restart();
      wq.delete();
      load_table(8'h10, 10'd0, 10'd0);
      encode(8'h10, lat);
      checks++;
      if (lat > 1 || wq.size() != 0) begin
         errors++;
         $display("[TB] FAIL zero_drop: got lat %0d words %0d, want lat <=1 words 0", lat, wq.size());
      end
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0000), rec(1, 0, 16'h0001)};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL zero_flush_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
      wq.delete();
      encode(8'h10, lat);
      encode(8'h41, lat);
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0000), rec(1, 0, 16'h0002)};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL zero_ptr_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   task automatic test_restart();
      int lat;
      logic [17:0] exp[4];
      wq.delete();
      encode(8'h41, lat);
      do_restart();
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0000), rec(1, 0, 16'h0001)};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL restart_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      int lat;
      logic [17:0] exp[4];
      do_restart();
      wq.delete();
      encode(8'h07, lat);
      encode(8'h07, lat);
      enc_ready_i = 1'b0;
      symb_i      = 8'h07;
      sym_valid_i = 1'b1;
      tick();
      sym_valid_i = 1'b0;
      checks++;
      if (enc_valid_o !== 1'b1) begin
         errors++;
         $display("[TB] FAIL areset_pending: got valid %b, want 1", enc_valid_o);
      end
      #2 rst_ni = 1'b0;
      #1;
      checks++;
      if ({enc_valid_o, busy_o, enc_o} !== 18'h0) begin
         errors++;
         $display("[TB] FAIL areset_immediate: got %h, want 00000", {enc_valid_o, busy_o, enc_o});
      end
      tick();
      rst_ni      = 1'b1;
      enc_ready_i = 1'b1;
      tick();
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0000), rec(1, 0, 16'h0001)};
      checks++;
      if (wq.size() != 4) begin
         errors++;
         $display("[TB] FAIL areset_count: got %0d, want 4", wq.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL areset_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   task automatic test_write_priority();
      int lat;
      logic [17:0] exp[4];
      wq.delete();
      freq_wr_i   = 1'b1;
      symb_i      = 8'h41;
      freq_i      = 10'd1;
      cum_freq_i  = 10'd5;
      sym_valid_i = 1'b1;
      #1;
      checks++;
      if (sym_ready_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrprio_ready: got %b, want 0", sym_ready_o);
      end
      tick();
      freq_wr_i   = 1'b0;
      sym_valid_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrprio_no_accept: got busy %b, want 0", busy_o);
      end
      encode(8'h41, lat);
      checks++;
      if (lat != BASE_LAT) begin
         errors++;
         $display("[TB] FAIL wrprio_latency: got %0d, want %0d", lat, BASE_LAT);
      end
      do_flush();
      exp = '{rec(0, 1, 16'h0000), rec(0, 1, 16'h0001), rec(0, 0, 16'h0005), rec(1, 0, 16'h0400)};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wq.size() || wq[i] !== exp[i]) begin
            errors++;
            $display("[TB] FAIL wrprio_word%0d: got %h, want %h", i, (i < wq.size()) ? wq[i] : 18'bx, exp[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_encode_flush();
      test_renorm();
      test_stall();
      test_zero_freq();
      test_restart();
      test_async_reset();
      test_write_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
